// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction-fetch sequencer owning the PC and the fetch handshake
// Fetches a word, hands it to IR, waits for execute, then selects PC+1 / jump / branch / halt.
module pc_sequencer #(
  parameter int                WIDTH        = 16,
  parameter logic [WIDTH-1:0]  RESET_PC     = 16'h0000,
  parameter int                WAIT_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             ir_load,
  output logic [WIDTH-1:0] ir_data,
  input  logic             exec_done,
  input  logic [1:0]       pc_sel,
  input  logic [WIDTH-1:0] sr1_out,
  input  logic [7:0]       br_offset,
  input  logic             br_taken,
  output logic [WIDTH-1:0] pc,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  // Counter value seen during the last request cycle that may still accept an ack
  localparam logic [7:0] TO_LAST = 8'(WAIT_TIMEOUT - 1);

  state_t           cur, nxt;
  logic [WIDTH-1:0] pc_q, pc_n;
  logic [WIDTH-1:0] ir_q, ir_n;
  logic [7:0]       cnt_q, cnt_n;
  logic             first_q, first_n;
  logic [WIDTH-1:0] pc_inc, br_target;

  assign pc_inc    = pc_q + WIDTH'(1);
  assign br_target = pc_inc + {{(WIDTH-8){br_offset[7]}}, br_offset};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur     <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      cur     <= nxt;
      pc_q    <= pc_n;
      ir_q    <= ir_n;
      cnt_q   <= cnt_n;
      first_q <= first_n;
    end
  end

  always_comb begin
    nxt     = cur;
    pc_n    = pc_q;
    ir_n    = ir_q;
    cnt_n   = cnt_q;
    first_n = 1'b0;
    case (cur)
      S_IDLE: begin
        if (run) nxt = S_REQ;
      end
      S_REQ: begin
        if (mem_ack) begin
          ir_n    = mem_rdata;
          cnt_n   = '0;
          first_n = 1'b1;
          nxt     = S_EXEC;
        end else if (cnt_q == TO_LAST) begin
          cnt_n = '0;
          nxt   = S_FAULT;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          case (pc_sel)
            2'b00:   pc_n = pc_inc;
            2'b01:   pc_n = sr1_out;
            2'b10:   pc_n = br_taken ? br_target : pc_inc;
            default: pc_n = pc_q;
          endcase
          if (pc_sel == 2'b11) nxt = S_HALT;
          else                 nxt = run ? S_REQ : S_IDLE;
        end
      end
      default: ;
    endcase
  end

  assign mem_req  = (cur == S_REQ);
  assign mem_addr = mem_req ? pc_q : '0;
  assign ir_load  = (cur == S_EXEC) && first_q;
  assign ir_data  = ir_q;
  assign pc       = pc_q;
  assign halted   = (cur == S_HALT);
  assign fault    = (cur == S_FAULT);
  assign state    = cur;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
// Driver pushes expected fetch addresses / IR words; a monitor pops them on ack and ir_load.
module tb_pc_sequencer;

  logic        clock, reset, run;
  logic        mem_req, mem_ack, ir_load, exec_done, br_taken, halted, fault;
  logic [15:0] mem_addr, mem_rdata, ir_data, sr1_out, pc;
  logic [1:0]  pc_sel;
  logic [7:0]  br_offset;
  logic [2:0]  state;

  logic        w_run, w_mem_req, w_mem_ack, w_ir_load, w_exec_done, w_br_taken, w_halted, w_fault;
  logic [15:0] w_mem_addr, w_mem_rdata, w_ir_data, w_sr1_out, w_pc;
  logic [1:0]  w_pc_sel;
  logic [7:0]  w_br_offset;
  logic [2:0]  w_state;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_addr[$];
  logic [15:0] exp_ir[$];

  function automatic logic [15:0] memfn(input logic [15:0] a);
    return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3};
  endfunction

  assign mem_rdata = memfn(mem_addr);

  pc_sequencer dut (
    .clock(clock), .reset(reset), .run(run), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir_load(ir_load), .ir_data(ir_data),
    .exec_done(exec_done), .pc_sel(pc_sel), .sr1_out(sr1_out), .br_offset(br_offset),
    .br_taken(br_taken), .pc(pc), .halted(halted), .fault(fault), .state(state)
  );

  pc_sequencer #(.RESET_PC(16'hFFFF)) u_wrap (
    .clock(clock), .reset(reset), .run(w_run), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
    .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata), .ir_load(w_ir_load), .ir_data(w_ir_data),
    .exec_done(w_exec_done), .pc_sel(w_pc_sel), .sr1_out(w_sr1_out), .br_offset(w_br_offset),
    .br_taken(w_br_taken), .pc(w_pc), .halted(w_halted), .fault(w_fault), .state(w_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-low-phase, after the negedge drivers have settled
  always begin
    @(negedge clock);
    #2;
    if (!reset) begin
      if (mem_req && mem_ack) begin
        if (exp_addr.size() == 0) check("unexpected_fetch", {16'h0, mem_addr}, 32'hFFFF_FFFF);
        else check("fetch_addr", {16'h0, mem_addr}, {16'h0, exp_addr.pop_front()});
      end
      if (ir_load) begin
        if (exp_ir.size() == 0) check("unexpected_ir_load", {16'h0, ir_data}, 32'hFFFF_FFFF);
        else check("ir_data", {16'h0, ir_data}, {16'h0, exp_ir.pop_front()});
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0; mem_ack = 1'b0; exec_done = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_state", {29'h0, state}, 32'd0);
    check("rst_pc", {16'h0, pc}, 32'h0000);
    check("rst_ir", {16'h0, ir_data}, 32'h0000);
    check("rst_outs", {28'h0, mem_req, ir_load, halted, fault}, 32'h0);
    check("rst_addr", {16'h0, mem_addr}, 32'h0);
    reset = 1'b0;
  endtask

  // Called at a negedge; acks on the (waits+1)th request cycle, returns at the ir_load negedge
  task automatic do_fetch(input int waits, input logic [15:0] a, output int lat);
    lat = 0;
    while (!mem_req && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    if (!mem_req) begin
      check("fetch_timeout", 32'd0, 32'd1);
      return;
    end
    repeat (waits) @(negedge clock);
    mem_ack = 1'b1;
    exp_addr.push_back(a);
    exp_ir.push_back(memfn(a));
    @(negedge clock);
    mem_ack = 1'b0;
  endtask

  task automatic do_exec(input logic [1:0] sel, input logic [15:0] sr1,
                         input logic [7:0] off, input logic taken);
    exec_done = 1'b1; pc_sel = sel; sr1_out = sr1; br_offset = off; br_taken = taken;
    @(negedge clock);
    exec_done = 1'b0;
  endtask

  initial begin
    int lat, got, cnt, any_req;
    logic [15:0] wa [2];
    reset = 1'b1; run = 1'b0; mem_ack = 1'b0; exec_done = 1'b0;
    pc_sel = 2'b00; sr1_out = '0; br_offset = '0; br_taken = 1'b0;
    w_run = 1'b0; w_mem_ack = 1'b1; w_mem_rdata = 16'h1234; w_exec_done = 1'b1;
    w_pc_sel = 2'b00; w_sr1_out = '0; w_br_offset = '0; w_br_taken = 1'b0;
    do_reset();

    // Reset PC of FFFF wraps to 0000 on the second fetch
    check("wrap_rst_pc", {16'h0, w_pc}, 32'hFFFF);
    w_run = 1'b1;
    got = 0;
    for (int k = 0; k < 10 && got < 2; k++) begin
      @(negedge clock);
      if (w_mem_req) begin
        wa[got] = w_mem_addr;
        got++;
      end
    end
    w_run = 1'b0;
    check("wrap_fetches", got, 2);
    check("wrap_addr0", {16'h0, wa[0]}, 32'hFFFF);
    check("wrap_addr1", {16'h0, wa[1]}, 32'h0000);

    // Sequential fetch, one instruction every two cycles
    run = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      do_fetch(0, 16'(i), lat);
      if (i > 0) check("seq_back_to_back", lat, 0);
      if (i < 5) do_exec(2'b00, 16'h0, 8'h0, 1'b0);
    end
    // pc=5: jump, taken branch, re-jump, untaken branch
    do_exec(2'b01, 16'h0040, 8'h0, 1'b0);
    do_fetch(0, 16'h0040, lat);
    do_exec(2'b10, 16'h0, 8'hFC, 1'b1);
    check("br_taken_pc", {16'h0, pc}, 32'h003D);
    do_fetch(0, 16'h003D, lat);
    do_exec(2'b01, 16'h0040, 8'h0, 1'b0);
    do_fetch(0, 16'h0040, lat);
    do_exec(2'b10, 16'h0, 8'hFC, 1'b0);
    check("br_untaken_pc", {16'h0, pc}, 32'h0041);
    do_fetch(0, 16'h0041, lat);

    // Two wait states, ack on the third request cycle
    do_exec(2'b00, 16'h0, 8'h0, 1'b0);
    do_fetch(2, 16'h0042, lat);
    check("wait_exec_state", {29'h0, state}, 32'd2);
    check("wait_ir_load", {31'h0, ir_load}, 32'd1);

    // Jump to FFFF then wrap via PC+1
    do_exec(2'b01, 16'hFFFF, 8'h0, 1'b0);
    do_fetch(0, 16'hFFFF, lat);
    do_exec(2'b00, 16'h0, 8'h0, 1'b0);
    do_fetch(0, 16'h0000, lat);
    do_exec(2'b00, 16'h0, 8'h0, 1'b0);
    do_fetch(0, 16'h0001, lat);

    // Drop run mid-EXEC: instruction completes then parks in IDLE
    run = 1'b0;
    @(negedge clock);
    do_exec(2'b00, 16'h0, 8'h0, 1'b0);
    check("drop_state", {29'h0, state}, 32'd0);
    check("drop_pc", {16'h0, pc}, 32'h0002);
    any_req = 0;
    repeat (3) begin
      @(negedge clock);
      if (mem_req) any_req++;
    end
    check("drop_no_req", any_req, 0);

    // No ack: fault after exactly 15 request cycles
    run = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40 && !fault; k++) begin
      @(negedge clock);
      if (mem_req) cnt++;
    end
    check("to_req_cycles", cnt, 15);
    check("to_fault", {31'h0, fault}, 32'd1);
    check("to_state", {29'h0, state}, 32'd4);
    check("to_mem_req", {31'h0, mem_req}, 32'd0);
    check("to_pc", {16'h0, pc}, 32'h0002);
    repeat (3) @(negedge clock);
    check("to_stays", {29'h0, state}, 32'd4);

    // Halt
    do_reset();
    run = 1'b1;
    @(negedge clock);
    do_fetch(0, 16'h0000, lat);
    do_exec(2'b11, 16'h0055, 8'h0, 1'b0);
    check("halt_flag", {31'h0, halted}, 32'd1);
    check("halt_state", {29'h0, state}, 32'd3);
    check("halt_pc", {16'h0, pc}, 32'h0000);
    any_req = 0;
    repeat (5) begin
      @(negedge clock);
      if (mem_req) any_req++;
    end
    check("halt_no_req", any_req, 0);

    // Async reset while requesting at 0023
    do_reset();
    run = 1'b1;
    @(negedge clock);
    do_fetch(0, 16'h0000, lat);
    do_exec(2'b01, 16'h0023, 8'h0, 1'b0);
    check("pre_rst_addr", {15'h0, mem_req, mem_addr}, 32'h0001_0023);
    #1;
    reset = 1'b1;
    #1;
    check("async_outs", {28'h0, mem_req, ir_load, halted, fault}, 32'h0);
    check("async_addr", {16'h0, mem_addr}, 32'h0);
    check("async_pc", {16'h0, pc}, 32'h0000);
    check("async_state", {29'h0, state}, 32'd0);
    run = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    check("queues_drained", exp_addr.size() + exp_ir.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

endmodule
